// File: rtl/aux_driver_rf_transceiver_if.sv
// Packet-output handshake between the receive path / UART side and the AUX sequencer.
// Master raises req and pulses done; slave answers with grant and the timeout abort pulse.
interface aux_driver_rf_transceiver_if;
  logic rx_out_req;
  logic rx_out_done;
  logic rx_out_grant;
  logic rx_out_abort;

  modport master (
    output rx_out_req,
    output rx_out_done,
    input  rx_out_grant,
    input  rx_out_abort
  );

  modport slave (
    input  rx_out_req,
    input  rx_out_done,
    output rx_out_grant,
    output rx_out_abort
  );
endinterface

// File: rtl/aux_driver_rf_transceiver.sv
// AUX pin sequencer: wakes the MCU PRE_WAKE_CYCLES before granting UART output and holds AUX low afterwards.
// All outputs registered (1 cycle); req waits in IDLE while mode/power-on not ready; AUX rise is delayed by RISE_DELAY.
module aux_driver_rf_transceiver #(
  parameter int   PRE_WAKE_CYCLES  = 3000,
  parameter int   POST_HOLD_CYCLES = 3000,
  parameter int   RISE_DELAY       = 1500,
  parameter int   GRANT_TIMEOUT    = 150000,
  parameter logic AUX_POWER_ON     = 1'b0
) (
  input  logic                         internal_clk,
  input  logic                         rst_n,
  input  logic                         AUX_mode_ctrl,
  input  logic                         AUX_power_on_ctrl,
  input  logic                         AUX_state_ctrl,
  aux_driver_rf_transceiver_if.slave   rx_if,
  output logic                         AUX_uart_ctrl,
  output logic                         AUX
);

  localparam int MAX_PH  = (PRE_WAKE_CYCLES > POST_HOLD_CYCLES) ? PRE_WAKE_CYCLES : POST_HOLD_CYCLES;
  localparam int MAX_CNT = (MAX_PH > GRANT_TIMEOUT) ? MAX_PH : GRANT_TIMEOUT;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int RISE_W  = (RISE_DELAY > 0) ? $clog2(RISE_DELAY + 1) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRE_WAKE  = 2'd1;
  localparam logic [1:0] ST_GRANT     = 2'd2;
  localparam logic [1:0] ST_POST_HOLD = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [RISE_W-1:0] rise_cnt;
  logic              ready_all;

  // Shared phase counter: every transition clears it so each state counts from zero.
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      rx_if.rx_out_grant  <= 1'b0;
      rx_if.rx_out_abort  <= 1'b0;
      AUX_uart_ctrl       <= 1'b1;
    end else begin
      rx_if.rx_out_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_if.rx_out_req && AUX_mode_ctrl && AUX_power_on_ctrl) begin
            state         <= ST_PRE_WAKE;
            cnt           <= '0;
            AUX_uart_ctrl <= 1'b0;
          end
        end
        ST_PRE_WAKE: begin
          if (!rx_if.rx_out_req) begin
            state <= ST_POST_HOLD;
            cnt   <= '0;
          end else if (cnt == CNT_W'(PRE_WAKE_CYCLES - 1)) begin
            state              <= ST_GRANT;
            cnt                <= '0;
            rx_if.rx_out_grant <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GRANT: begin
          // done has priority over a timeout landing in the same cycle
          if (rx_if.rx_out_done) begin
            state              <= ST_POST_HOLD;
            cnt                <= '0;
            rx_if.rx_out_grant <= 1'b0;
          end else if (cnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
            state              <= ST_POST_HOLD;
            cnt                <= '0;
            rx_if.rx_out_grant <= 1'b0;
            rx_if.rx_out_abort <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_POST_HOLD: begin
          if (cnt == CNT_W'(POST_HOLD_CYCLES - 1)) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            AUX_uart_ctrl <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ready_all = AUX_mode_ctrl & AUX_power_on_ctrl & AUX_state_ctrl & AUX_uart_ctrl;

  // Falls one cycle after any source drops; rises only after RISE_DELAY+1 uninterrupted ready cycles.
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
      AUX      <= AUX_POWER_ON;
    end else if (!ready_all) begin
      rise_cnt <= '0;
      AUX      <= 1'b0;
    end else if (rise_cnt == RISE_W'(RISE_DELAY)) begin
      AUX <= 1'b1;
    end else begin
      rise_cnt <= rise_cnt + 1'b1;
    end
  end

endmodule
